// File: rtl/regbus_initiator.sv
// Purpose : parallel register-bus master; turns one valid/ready command into a cs/addr/data/wr-strobe bus cycle.
// Latency : write SETUP+PULSE+HOLD+2, read SETUP+READ+2 cycles between acceptances; rspValid pulses in RESP.
// Backpr. : cmdReady only in IDLE (one command in flight, nothing queued); the response has no backpressure.
// Ports   : clk/reset (sync, active-high); cmd* = command in; rsp* = completion; bus* / wr0..3 = register bus; busy = not IDLE.
module regbus_initiator #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int READ_CYC  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic        cmdWrite,
    input  logic [11:0] cmdAddr,
    input  logic [31:0] cmdData,
    input  logic [3:0]  cmdBe,
    output logic        rspValid,
    output logic [31:0] rspData,
    output logic [11:0] busAddr,
    output logic [31:0] busDataOut,
    input  logic [31:0] busDataIn,
    output logic        busCs,
    output logic        wr0,
    output logic        wr1,
    output logic        wr2,
    output logic        wr3,
    output logic        busy
);

    if (SETUP_CYC < 1 || SETUP_CYC > 255 || PULSE_CYC < 1 || PULSE_CYC > 255 ||
        HOLD_CYC < 1 || HOLD_CYC > 255 || READ_CYC < 1 || READ_CYC > 255) begin : gParamCheck
        $error("regbus_initiator: timing parameters must lie in 1..255");
    end

    // Counter load values: a load of N-1 gives N cycles in the state.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
    localparam logic [7:0] READ_LD  = 8'(READ_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RDWAIT, RESP} stateT;

    stateT       state, stateNext;
    logic [7:0]  cnt, cntNext;
    logic        opWrite, opWriteNext;
    logic [3:0]  opBe, opBeNext;
    logic [3:0]  wrQ, wrNext;
    logic        csNext;
    logic        cmdReadyNext;
    logic        rspValidNext;
    logic [31:0] rspDataNext;
    logic [11:0] busAddrNext;
    logic [31:0] busDataOutNext;

    // Every bus-facing output is the next-value of a flop computed here, so
    // the strobes the targets use as clocks never see combinational logic.
    always_comb begin
        stateNext      = state;
        cntNext        = cnt;
        opWriteNext    = opWrite;
        opBeNext       = opBe;
        wrNext         = 4'b0000;
        csNext         = busCs;
        rspValidNext   = 1'b0;
        rspDataNext    = rspData;
        busAddrNext    = busAddr;
        busDataOutNext = busDataOut;
        case (state)
            IDLE: begin
                if (cmdValid && cmdReady) begin
                    opWriteNext = cmdWrite;
                    opBeNext    = cmdBe;
                    busAddrNext = cmdAddr;
                    if (cmdWrite) begin
                        busDataOutNext = cmdData;
                    end
                    csNext    = 1'b1;
                    stateNext = SETUP;
                    cntNext   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    if (opWrite) begin
                        stateNext = STROBE;
                        cntNext   = PULSE_LD;
                        wrNext    = opBe;
                    end else begin
                        stateNext = RDWAIT;
                        cntNext   = READ_LD;
                    end
                end else begin
                    cntNext = cnt - 8'd1;
                end
            end
            STROBE: begin
                // Strobes stay up while counting; they drop on the exit edge.
                if (cnt == 8'd0) begin
                    stateNext = HOLD;
                    cntNext   = HOLD_LD;
                end else begin
                    cntNext = cnt - 8'd1;
                    wrNext  = opBe;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    stateNext    = RESP;
                    csNext       = 1'b0;
                    rspValidNext = 1'b1;
                    rspDataNext  = 32'd0;
                end else begin
                    cntNext = cnt - 8'd1;
                end
            end
            RDWAIT: begin
                if (cnt == 8'd0) begin
                    stateNext    = RESP;
                    csNext       = 1'b0;
                    rspValidNext = 1'b1;
                    rspDataNext  = busDataIn;
                end else begin
                    cntNext = cnt - 8'd1;
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
                csNext    = 1'b0;
            end
        endcase
        // Registered ready: high exactly while the FSM sits in IDLE, and low
        // for the first cycle after reset.
        cmdReadyNext = (stateNext == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            opWrite    <= 1'b0;
            opBe       <= 4'b0000;
            wrQ        <= 4'b0000;
            busCs      <= 1'b0;
            cmdReady   <= 1'b0;
            rspValid   <= 1'b0;
            rspData    <= 32'd0;
            busAddr    <= 12'd0;
            busDataOut <= 32'd0;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            opWrite    <= opWriteNext;
            opBe       <= opBeNext;
            wrQ        <= wrNext;
            busCs      <= csNext;
            cmdReady   <= cmdReadyNext;
            rspValid   <= rspValidNext;
            rspData    <= rspDataNext;
            busAddr    <= busAddrNext;
            busDataOut <= busDataOutNext;
        end
    end

    assign wr0  = wrQ[0];
    assign wr1  = wrQ[1];
    assign wr2  = wrQ[2];
    assign wr3  = wrQ[3];
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_regbus_initiator.sv
// Purpose : self-checking bench for regbus_initiator (default build and a SETUP/PULSE/HOLD/READ=1 build).
// Latency : expectations come from a timeline model built from the timing parameters.
// Backpr. : stimulus holds cmdValid until accepted; all waits are cycle-bounded.
module tb_regbus_initiator;

    localparam int S  = 2, P  = 2, H  = 1, R  = 3;
    localparam int FS = 1, FP = 1, FH = 1, FR = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        cmdValidA = 1'b0, cmdValidB = 1'b0;
    logic        cmdWrite = 1'b0;
    logic [11:0] cmdAddr = 12'd0;
    logic [31:0] cmdData = 32'd0;
    logic [3:0]  cmdBe = 4'd0;

    logic        cmdReadyA, rspValidA, busCsA, wrA0, wrA1, wrA2, wrA3, busyA;
    logic [31:0] rspDataA, busDataOutA, busDataInA;
    logic [11:0] busAddrA;
    logic        cmdReadyB, rspValidB, busCsB, wrB0, wrB1, wrB2, wrB3, busyB;
    logic [31:0] rspDataB, busDataOutB;
    logic [31:0] busDataInB = 32'h0BAD_F00D;
    logic [11:0] busAddrB;

    int total = 0;
    int bad   = 0;

    // Target register file for the default instance: bytes captured on the
    // falling edge of their strobe, using addr/data as seen mid-cycle before.
    logic [31:0] tgtMem [4096];
    logic [31:0] refMem [4096];
    logic        armed = 1'b0;
    logic [11:0] addrQ = 12'd0;
    logic [31:0] dataQ = 32'd0;
    int          riseB [4];

    assign busDataInA = tgtMem[busAddrA];

    always @(negedge clk) begin
        addrQ = busAddrA;
        dataQ = busDataOutA;
    end
    always @(negedge wrA0) if (armed) tgtMem[addrQ][7:0]   = dataQ[7:0];
    always @(negedge wrA1) if (armed) tgtMem[addrQ][15:8]  = dataQ[15:8];
    always @(negedge wrA2) if (armed) tgtMem[addrQ][23:16] = dataQ[23:16];
    always @(negedge wrA3) if (armed) tgtMem[addrQ][31:24] = dataQ[31:24];
    always @(posedge wrB0) if (armed) riseB[0]++;
    always @(posedge wrB1) if (armed) riseB[1]++;
    always @(posedge wrB2) if (armed) riseB[2]++;
    always @(posedge wrB3) if (armed) riseB[3]++;

    regbus_initiator dutA (
        .clk(clk), .reset(reset), .cmdValid(cmdValidA), .cmdReady(cmdReadyA),
        .cmdWrite(cmdWrite), .cmdAddr(cmdAddr), .cmdData(cmdData), .cmdBe(cmdBe),
        .rspValid(rspValidA), .rspData(rspDataA), .busAddr(busAddrA),
        .busDataOut(busDataOutA), .busDataIn(busDataInA), .busCs(busCsA),
        .wr0(wrA0), .wr1(wrA1), .wr2(wrA2), .wr3(wrA3), .busy(busyA)
    );

    regbus_initiator #(.SETUP_CYC(FS), .PULSE_CYC(FP), .HOLD_CYC(FH), .READ_CYC(FR)) dutB (
        .clk(clk), .reset(reset), .cmdValid(cmdValidB), .cmdReady(cmdReadyB),
        .cmdWrite(cmdWrite), .cmdAddr(cmdAddr), .cmdData(cmdData), .cmdBe(cmdBe),
        .rspValid(rspValidB), .rspData(rspDataB), .busAddr(busAddrB),
        .busDataOut(busDataOutB), .busDataIn(busDataInB), .busCs(busCsB),
        .wr0(wrB0), .wr1(wrB1), .wr2(wrB2), .wr3(wrB3), .busy(busyB)
    );

    // Timeline model. Sample n is taken mid-cycle after the n-th edge
    // following the acceptance edge (n=0 is right after acceptance).
    function automatic void txnModel(input int s, input int p, input int h, input int r,
                                     input bit wrt, input logic [3:0] be,
                                     output logic [15:0] eCs, output logic [15:0] eRv,
                                     output logic [15:0] eRdy, output logic [3:0][15:0] eWr);
        int busLen;
        int turn;
        busLen = wrt ? (s + p + h) : (s + r);
        turn   = busLen + 2;
        eCs  = 16'((32'd1 << busLen) - 32'd1);
        eRv  = 16'(32'd1 << busLen);
        eRdy = 16'(~((32'd1 << (turn - 1)) - 32'd1));
        for (int i = 0; i < 4; i++)
            eWr[i] = (wrt && be[i]) ? 16'(((32'd1 << p) - 32'd1) << s) : 16'd0;
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] be);
        logic [31:0] m;
        m = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) m[8*i +: 8] = d[8*i +: 8];
        return m;
    endfunction

    // Drives one command and records 16 mid-cycle samples after acceptance.
    task automatic doTxn(input bit selB, input bit wrt, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         output logic [15:0] oCs, output logic [15:0] oRv,
                         output logic [15:0] oRdy, output logic [3:0][15:0] oWr,
                         output logic [31:0] oRsp, output bit ok);
        oCs = '0; oRv = '0; oRdy = '0; oWr = '0; oRsp = 32'h5A5A_A5A5; ok = 1'b0;
        @(negedge clk);
        cmdWrite = wrt; cmdAddr = a; cmdData = d; cmdBe = be;
        if (selB) cmdValidB = 1'b1; else cmdValidA = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (selB ? cmdReadyB : cmdReadyA) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) begin
            for (int n = 0; n < 16; n++) begin
                @(negedge clk);
                cmdValidA = 1'b0;
                cmdValidB = 1'b0;
                if (selB) begin
                    oCs[n] = busCsB; oRv[n] = rspValidB; oRdy[n] = cmdReadyB;
                    oWr[0][n] = wrB0; oWr[1][n] = wrB1; oWr[2][n] = wrB2; oWr[3][n] = wrB3;
                    if (rspValidB) oRsp = rspDataB;
                end else begin
                    oCs[n] = busCsA; oRv[n] = rspValidA; oRdy[n] = cmdReadyA;
                    oWr[0][n] = wrA0; oWr[1][n] = wrA1; oWr[2][n] = wrA2; oWr[3][n] = wrA3;
                    if (rspValidA) oRsp = rspDataA;
                end
            end
        end else begin
            cmdValidA = 1'b0;
            cmdValidB = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({cmdReadyA, rspValidA, busCsA, wrA3, wrA2, wrA1, wrA0, busyA, cmdReadyB, busCsB, busyB} !== 11'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b required=0", {cmdReadyA, rspValidA, busCsA, wrA3, wrA2, wrA1, wrA0, busyA, cmdReadyB, busCsB, busyB});
        end
        total++;
        if ({rspDataA, busAddrA, busDataOutA} !== 76'd0) begin
            bad++;
            $display("FAIL reset_data got=%h required=0", {rspDataA, busAddrA, busDataOutA});
        end
        reset = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        total++;
        if ({cmdReadyA, cmdReadyB} !== 2'b11) begin
            bad++;
            $display("FAIL reset_ready got=%b required=11", {cmdReadyA, cmdReadyB});
        end
    endtask

    task automatic test_write_full();
        logic [15:0] oCs, oRv, oRdy, eCs, eRv, eRdy;
        logic [3:0][15:0] oWr, eWr;
        logic [31:0] oRsp;
        bit ok;
        doTxn(1'b0, 1'b1, 12'h010, 32'hA5A5_1234, 4'hF, oCs, oRv, oRdy, oWr, oRsp, ok);
        txnModel(S, P, H, R, 1'b1, 4'hF, eCs, eRv, eRdy, eWr);
        refMem[12'h010] = mergeBytes(refMem[12'h010], 32'hA5A5_1234, 4'hF);
        total++;
        if (!ok || {oCs, oRv, oRdy, oWr} !== {eCs, eRv, eRdy, eWr}) begin
            bad++;
            $display("FAIL wr_full_wave ok=%0d got=%h required=%h", ok, {oCs, oRv, oRdy, oWr}, {eCs, eRv, eRdy, eWr});
        end
        total++;
        if (oRsp !== 32'd0) begin
            bad++;
            $display("FAIL wr_full_rsp got=%h required=0", oRsp);
        end
        total++;
        if (tgtMem[12'h010] !== 32'hA5A5_1234) begin
            bad++;
            $display("FAIL wr_full_mem got=%h required=a5a51234", tgtMem[12'h010]);
        end
        total++;
        if ({busAddrA, busDataOutA, busCsA} !== {12'h010, 32'hA5A5_1234, 1'b0}) begin
            bad++;
            $display("FAIL wr_full_idle_hold got=%h required=%h", {busAddrA, busDataOutA, busCsA}, {12'h010, 32'hA5A5_1234, 1'b0});
        end
    endtask

    task automatic test_write_partial();
        logic [15:0] oCs, oRv, oRdy, eCs, eRv, eRdy;
        logic [3:0][15:0] oWr, eWr;
        logic [31:0] oRsp;
        bit ok;
        tgtMem[12'h014] = 32'hFFFF_FFFF;
        refMem[12'h014] = 32'hFFFF_FFFF;
        doTxn(1'b0, 1'b1, 12'h014, 32'h1122_3344, 4'b0101, oCs, oRv, oRdy, oWr, oRsp, ok);
        txnModel(S, P, H, R, 1'b1, 4'b0101, eCs, eRv, eRdy, eWr);
        refMem[12'h014] = mergeBytes(refMem[12'h014], 32'h1122_3344, 4'b0101);
        total++;
        if (!ok || {oCs, oRv, oRdy, oWr} !== {eCs, eRv, eRdy, eWr}) begin
            bad++;
            $display("FAIL wr_part_wave ok=%0d got=%h required=%h", ok, {oCs, oRv, oRdy, oWr}, {eCs, eRv, eRdy, eWr});
        end
        total++;
        if (tgtMem[12'h014] !== 32'hFF22_FF44) begin
            bad++;
            $display("FAIL wr_part_mem got=%h required=ff22ff44", tgtMem[12'h014]);
        end
    endtask

    task automatic test_read();
        logic [15:0] oCs, oRv, oRdy, eCs, eRv, eRdy;
        logic [3:0][15:0] oWr, eWr;
        logic [31:0] oRsp;
        bit ok;
        tgtMem[12'h020] = 32'hDEAD_BEEF;
        refMem[12'h020] = 32'hDEAD_BEEF;
        doTxn(1'b0, 1'b0, 12'h020, 32'h7777_7777, 4'hF, oCs, oRv, oRdy, oWr, oRsp, ok);
        txnModel(S, P, H, R, 1'b0, 4'hF, eCs, eRv, eRdy, eWr);
        total++;
        if (!ok || {oCs, oRv, oRdy, oWr} !== {eCs, eRv, eRdy, eWr}) begin
            bad++;
            $display("FAIL rd_wave ok=%0d got=%h required=%h", ok, {oCs, oRv, oRdy, oWr}, {eCs, eRv, eRdy, eWr});
        end
        total++;
        if (oRsp !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL rd_data got=%h required=deadbeef", oRsp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] acc, cs, expAcc, expCs;
        int rvCnt, busLen, turn;
        bit second;
        acc = '0; cs = '0; rvCnt = 0; second = 1'b0;
        busLen = S + P + H;
        turn   = busLen + 2;
        expAcc = 32'd1 | (32'd1 << turn);
        expCs  = ((32'd1 << busLen) - 32'd1) | (((32'd1 << busLen) - 32'd1) << turn);
        @(negedge clk);
        cmdWrite = 1'b1; cmdAddr = 12'h040; cmdData = 32'h0101_0101; cmdBe = 4'hF;
        cmdValidA = 1'b1;
        for (int n = 0; n < 24; n++) begin
            acc[n] = cmdValidA & cmdReadyA;
            @(negedge clk);
            cs[n] = busCsA;
            if (rspValidA) rvCnt++;
            if (acc[n]) begin
                if (!second) begin
                    second  = 1'b1;
                    cmdAddr = 12'h044;
                    cmdData = 32'h0202_0202;
                end else begin
                    cmdValidA = 1'b0;
                end
            end
        end
        cmdValidA = 1'b0;
        refMem[12'h040] = 32'h0101_0101;
        refMem[12'h044] = 32'h0202_0202;
        total++;
        if (acc !== expAcc) begin
            bad++;
            $display("FAIL b2b_accept got=%h required=%h", acc, expAcc);
        end
        total++;
        if (cs !== expCs) begin
            bad++;
            $display("FAIL b2b_cs got=%h required=%h", cs, expCs);
        end
        total++;
        if (rvCnt !== 2) begin
            bad++;
            $display("FAIL b2b_rsp_count got=%0d required=2", rvCnt);
        end
        total++;
        if ({tgtMem[12'h040], tgtMem[12'h044]} !== {refMem[12'h040], refMem[12'h044]}) begin
            bad++;
            $display("FAIL b2b_mem got=%h required=%h", {tgtMem[12'h040], tgtMem[12'h044]}, {refMem[12'h040], refMem[12'h044]});
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] oCs, oRv, oRdy, eCs, eRv, eRdy;
        logic [3:0][15:0] oWr, eWr;
        logic [31:0] oRsp, d;
        bit ok, rvSeen;
        @(negedge clk);
        cmdWrite = 1'b1; cmdAddr = 12'h030; cmdData = 32'hCAFE_0001; cmdBe = 4'hF;
        cmdValidA = 1'b1;
        total++;
        if (cmdReadyA !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_ready_before got=%b required=1", cmdReadyA);
        end
        @(negedge clk);
        cmdValidA = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({wrA3, wrA2, wrA1, wrA0, busCsA} !== 5'b11111) begin
            bad++;
            $display("FAIL rstmid_strobe got=%b required=11111", {wrA3, wrA2, wrA1, wrA0, busCsA});
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({wrA3, wrA2, wrA1, wrA0, busCsA, rspValidA, cmdReadyA, busyA} !== 8'b0) begin
            bad++;
            $display("FAIL rstmid_cleared got=%b required=0", {wrA3, wrA2, wrA1, wrA0, busCsA, rspValidA, cmdReadyA, busyA});
        end
        reset = 1'b0;
        rvSeen = 1'b0;
        @(negedge clk);
        rvSeen |= rspValidA;
        total++;
        if (cmdReadyA !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_ready_after got=%b required=1", cmdReadyA);
        end
        repeat (6) begin
            @(negedge clk);
            rvSeen |= rspValidA;
        end
        total++;
        if (rvSeen !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_no_rsp got=%b required=0", rvSeen);
        end
        refMem[12'h030] = 32'hCAFE_0001;
        total++;
        if (tgtMem[12'h030] !== 32'hCAFE_0001) begin
            bad++;
            $display("FAIL rstmid_commit got=%h required=cafe0001", tgtMem[12'h030]);
        end
        d = $urandom;
        doTxn(1'b0, 1'b1, 12'h034, d, 4'hC, oCs, oRv, oRdy, oWr, oRsp, ok);
        txnModel(S, P, H, R, 1'b1, 4'hC, eCs, eRv, eRdy, eWr);
        refMem[12'h034] = mergeBytes(refMem[12'h034], d, 4'hC);
        total++;
        if (!ok || {oCs, oRv, oRdy, oWr} !== {eCs, eRv, eRdy, eWr} || tgtMem[12'h034] !== refMem[12'h034]) begin
            bad++;
            $display("FAIL rstmid_recover ok=%0d got=%h/%h required=%h/%h", ok, {oCs, oRv, oRdy, oWr}, tgtMem[12'h034], {eCs, eRv, eRdy, eWr}, refMem[12'h034]);
        end
    endtask

    task automatic test_fast_build();
        logic [15:0] oCs, oRv, oRdy, eCs, eRv, eRdy;
        logic [3:0][15:0] oWr, eWr;
        logic [31:0] oRsp, d, rises, expRises;
        bit ok;
        d = $urandom;
        for (int i = 0; i < 4; i++) riseB[i] = 0;
        doTxn(1'b1, 1'b1, 12'h0C0, d, 4'b1011, oCs, oRv, oRdy, oWr, oRsp, ok);
        txnModel(FS, FP, FH, FR, 1'b1, 4'b1011, eCs, eRv, eRdy, eWr);
        total++;
        if (!ok || {oCs, oRv, oRdy, oWr} !== {eCs, eRv, eRdy, eWr}) begin
            bad++;
            $display("FAIL fast_wr_wave ok=%0d got=%h required=%h", ok, {oCs, oRv, oRdy, oWr}, {eCs, eRv, eRdy, eWr});
        end
        rises    = {8'(riseB[3]), 8'(riseB[2]), 8'(riseB[1]), 8'(riseB[0])};
        expRises = 32'h0100_0101;
        total++;
        if (rises !== expRises) begin
            bad++;
            $display("FAIL fast_wr_edges got=%h required=%h", rises, expRises);
        end
        total++;
        if ({busAddrB, busDataOutB} !== {12'h0C0, d}) begin
            bad++;
            $display("FAIL fast_bus_hold got=%h required=%h", {busAddrB, busDataOutB}, {12'h0C0, d});
        end
        for (int i = 0; i < 4; i++) riseB[i] = 0;
        doTxn(1'b1, 1'b0, 12'h0C4, 32'd0, 4'hF, oCs, oRv, oRdy, oWr, oRsp, ok);
        txnModel(FS, FP, FH, FR, 1'b0, 4'hF, eCs, eRv, eRdy, eWr);
        rises = {8'(riseB[3]), 8'(riseB[2]), 8'(riseB[1]), 8'(riseB[0])};
        total++;
        if (!ok || {oCs, oRv, oRdy, oWr} !== {eCs, eRv, eRdy, eWr} || rises !== 32'd0) begin
            bad++;
            $display("FAIL fast_rd_wave ok=%0d got=%h/%h required=%h/0", ok, {oCs, oRv, oRdy, oWr}, rises, {eCs, eRv, eRdy, eWr});
        end
        total++;
        if (oRsp !== busDataInB) begin
            bad++;
            $display("FAIL fast_rd_data got=%h required=%h", oRsp, busDataInB);
        end
    endtask

    task automatic test_random();
        logic [15:0] oCs, oRv, oRdy, eCs, eRv, eRdy;
        logic [3:0][15:0] oWr, eWr;
        logic [31:0] oRsp, d, expRsp;
        logic [11:0] a;
        logic [3:0] be;
        bit ok, wrt;
        for (int it = 0; it < 16; it++) begin
            wrt = 1'($urandom_range(0, 1));
            a   = 12'h100 + 12'($urandom_range(0, 3) * 4);
            d   = $urandom;
            be  = 4'($urandom_range(0, 15));
            doTxn(1'b0, wrt, a, d, be, oCs, oRv, oRdy, oWr, oRsp, ok);
            txnModel(S, P, H, R, wrt, be, eCs, eRv, eRdy, eWr);
            if (wrt) begin
                refMem[a] = mergeBytes(refMem[a], d, be);
                expRsp = 32'd0;
            end else begin
                expRsp = refMem[a];
            end
            total++;
            if (!ok || {oCs, oRv, oRdy, oWr} !== {eCs, eRv, eRdy, eWr}) begin
                bad++;
                $display("FAIL rand_wave it=%0d wr=%0d be=%h got=%h required=%h", it, wrt, be, {oCs, oRv, oRdy, oWr}, {eCs, eRv, eRdy, eWr});
            end
            total++;
            if (oRsp !== expRsp) begin
                bad++;
                $display("FAIL rand_rsp it=%0d wr=%0d addr=%h got=%h required=%h", it, wrt, a, oRsp, expRsp);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            tgtMem[i] = 32'd0;
            refMem[i] = 32'd0;
        end
        for (int i = 0; i < 4; i++) riseB[i] = 0;
        test_reset();
        test_write_full();
        test_write_partial();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_fast_build();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
